// File: rtl/id_stage_if.sv
// Fetch / execute / writeback signal bundle around the decode-issue stage.
// The slave modport is the decode stage; master is whatever surrounds it.
interface id_stage_if #(parameter int DW = 16);
  logic [31:0]   id_instr;
  logic [15:0]   fe_pc;
  logic          Stall;
  logic          Loop;
  logic [15:0]   PC_in;
  logic          ex_stall;
  logic          ex_valid;
  logic [4:0]    ex_op;
  logic [3:0]    ex_rd;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [15:0]   ex_imm;
  logic [15:0]   ex_pc;
  logic          wb_we;
  logic [3:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          halted;
  logic          illegal;

  modport master (
    output id_instr, fe_pc, ex_stall, wb_we, wb_rd, wb_data,
    input  Stall, Loop, PC_in, ex_valid, ex_op, ex_rd, ex_a, ex_b,
           ex_imm, ex_pc, halted, illegal
  );

  modport slave (
    input  id_instr, fe_pc, ex_stall, wb_we, wb_rd, wb_data,
    output Stall, Loop, PC_in, ex_valid, ex_op, ex_rd, ex_a, ex_b,
           ex_imm, ex_pc, halted, illegal
  );
endinterface

// File: rtl/id_stage.sv
// Decode / issue stage: register file with writeback bypass, RAW scoreboard,
// branch resolution back to fetch, and a registered issue slot to execute.
module id_stage #(
  parameter int NREG = 16,
  parameter int DW   = 16
) (
  input logic       CLOCK_50,
  input logic       reset,
  id_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    op;
    logic [3:0]    rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [15:0]   imm;
    logic [15:0]   pc;
  } issue_t;

  logic [4:0]    op;
  logic [3:0]    rd, rs, rt;
  logic [15:0]   imm;
  logic [DW-1:0] rf [NREG];
  logic [NREG-1:0] busy, busy_nxt;
  logic [15:0]   id_pc;
  logic          squash, halted, illegal;
  issue_t        ex_q;

  logic uses_rs, uses_rt, wr_rd, is_exop, legal, is_bnz, is_jmp, is_halt;
  logic [DW-1:0] a_val, b_val;
  logic rs_busy, rt_busy, hazard, issue, take;

  assign op  = bus.id_instr[31:27];
  assign rd  = bus.id_instr[26:23];
  assign rs  = bus.id_instr[22:19];
  assign rt  = bus.id_instr[18:15];
  assign imm = bus.id_instr[15:0];

  always_comb begin
    uses_rs = (op inside {[5'h01:5'h11]}) || (op == 5'h18);
    uses_rt = (op inside {[5'h01:5'h07]}) || (op == 5'h11);
    wr_rd   = op inside {[5'h01:5'h10]};
    is_exop = op inside {[5'h01:5'h11]};
    is_bnz  = (op == 5'h18);
    is_jmp  = (op == 5'h19);
    is_halt = (op == 5'h1F);
    legal   = (op inside {[5'h00:5'h11]}) || is_bnz || is_jmp || is_halt;
  end

  // Writeback in the same cycle is visible both as data and as a busy clear.
  always_comb begin
    a_val   = (rs == 4'd0) ? '0 : (bus.wb_we && bus.wb_rd == rs) ? bus.wb_data : rf[rs];
    b_val   = (rt == 4'd0) ? '0 : (bus.wb_we && bus.wb_rd == rt) ? bus.wb_data : rf[rt];
    rs_busy = busy[rs] && !(bus.wb_we && bus.wb_rd == rs);
    rt_busy = busy[rt] && !(bus.wb_we && bus.wb_rd == rt);
  end

  assign hazard = (uses_rs && rs_busy) || (uses_rt && rt_busy) || bus.ex_stall;
  assign issue  = !halted && !squash && !hazard;
  assign take   = issue && (is_jmp || (is_bnz && a_val != '0));

  // The squash cycle must let fetch advance so the branch target arrives.
  assign bus.Stall = halted || (!squash && hazard);
  assign bus.Loop  = take;
  assign bus.PC_in = !take ? 16'd0 : is_jmp ? imm : id_pc + 16'd1 + imm;

  always_comb begin
    busy_nxt = busy;
    if (bus.wb_we) busy_nxt[bus.wb_rd] = 1'b0;
    if (issue && wr_rd && rd != 4'd0) busy_nxt[rd] = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      busy    <= '0;
      id_pc   <= '0;
      squash  <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      ex_q    <= '0;
    end else begin
      if (!bus.Stall) id_pc <= bus.fe_pc;
      if (bus.wb_we && bus.wb_rd != 4'd0) rf[bus.wb_rd] <= bus.wb_data;
      busy   <= busy_nxt;
      squash <= take;
      if (issue && is_halt) halted  <= 1'b1;
      if (issue && !legal)  illegal <= 1'b1;
      if (!bus.ex_stall) begin
        if (issue) begin
          ex_q.valid <= is_exop;
          ex_q.op    <= op;
          ex_q.rd    <= rd;
          ex_q.a     <= a_val;
          ex_q.b     <= b_val;
          ex_q.imm   <= imm;
          ex_q.pc    <= id_pc;
        end else begin
          ex_q.valid <= 1'b0;
        end
      end
    end
  end

  assign bus.ex_valid = ex_q.valid;
  assign bus.ex_op    = ex_q.op;
  assign bus.ex_rd    = ex_q.rd;
  assign bus.ex_a     = ex_q.a;
  assign bus.ex_b     = ex_q.b;
  assign bus.ex_imm   = ex_q.imm;
  assign bus.ex_pc    = ex_q.pc;
  assign bus.halted   = halted;
  assign bus.illegal  = illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, halt/illegal/reset sequence,
// and random traffic against an instruction-level reference model.
module tb_id_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.CLOCK_50(clk), .reset(reset), .bus(bus.slave));

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [15:0] m_rf [16];
  bit          m_busy [16];
  logic [15:0] m_idpc;
  bit          m_sq, m_halt, m_ill;
  bit          e_v;
  logic [4:0]  e_op;
  logic [3:0]  e_rd;
  logic [15:0] e_a, e_b, e_imm, e_pc;

  // comb outputs sampled during the last step
  bit          s_stall, s_loop;
  logic [15:0] s_pcin;

  typedef struct {
    logic [31:0] ins;
    logic [15:0] fpc;
    bit          exs, we;
    logic [3:0]  wrd;
    logic [15:0] wd;
    bit          st, lp;
    logic [15:0] pcin;
    bit          v;
    logic [15:0] a, pc;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rr(input logic [4:0] op, input logic [3:0] d, s, t);
    return {op, d, s, t, 15'h0};
  endfunction

  function automatic logic [31:0] ri(input logic [4:0] op, input logic [3:0] d, s, input logic [15:0] im);
    return {op, d, s, 3'b000, im};
  endfunction

  function automatic vec_t mkv(input logic [31:0] ins, input logic [15:0] fpc, input bit exs, we,
                               input logic [3:0] wrd, input logic [15:0] wd, input bit st, lp,
                               input logic [15:0] pcin, input bit v, input logic [15:0] a, pc);
    vec_t r;
    r.ins = ins; r.fpc = fpc; r.exs = exs; r.we = we; r.wrd = wrd; r.wd = wd;
    r.st = st; r.lp = lp; r.pcin = pcin; r.v = v; r.a = a; r.pc = pc;
    return r;
  endfunction

  function automatic logic [15:0] rdv(input logic [3:0] r, input bit we, input logic [3:0] wrd,
                                      input logic [15:0] wd);
    if (r == 0) return 16'h0;
    if (we && wrd == r) return wd;
    return m_rf[r];
  endfunction

  function automatic bit bsy(input logic [3:0] r, input bit we, input logic [3:0] wrd);
    return (r != 0) && m_busy[r] && !(we && wrd == r);
  endfunction

  // One clock: drive, check comb outputs, advance model, check registered outputs.
  task automatic step(input bit rst, input logic [31:0] ins, input logic [15:0] fpc, input bit exs,
                      input bit we, input logic [3:0] wrd, input logic [15:0] wd);
    logic [4:0] op; logic [3:0] rd, rs, rt; logic [15:0] imm, av, bv, pcin;
    bit rdsA, rdsB, wrs, exop, legal, hz, go, lp, st;
    reset = rst; bus.id_instr = ins; bus.fe_pc = fpc; bus.ex_stall = exs;
    bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wd;
    #2;
    op = ins[31:27]; rd = ins[26:23]; rs = ins[22:19]; rt = ins[18:15]; imm = ins[15:0];
    rdsA  = (op >= 5'd1 && op <= 5'd17) || op == 5'd24;
    rdsB  = (op >= 5'd1 && op <= 5'd7) || op == 5'd17;
    wrs   = (op >= 5'd1 && op <= 5'd16);
    exop  = (op >= 5'd1 && op <= 5'd17);
    legal = (op <= 5'd17) || op == 5'd24 || op == 5'd25 || op == 5'd31;
    av = rdv(rs, we, wrd, wd);
    bv = rdv(rt, we, wrd, wd);
    hz = (rdsA && bsy(rs, we, wrd)) || (rdsB && bsy(rt, we, wrd)) || exs;
    go = !m_halt && !m_sq && !hz;
    lp = go && (op == 5'd25 || (op == 5'd24 && av != 0));
    pcin = !lp ? 16'h0 : (op == 5'd25) ? imm : 16'(m_idpc + 16'd1 + imm);
    st = m_halt || (!m_sq && hz);
    s_stall = bus.Stall; s_loop = bus.Loop; s_pcin = bus.PC_in;
    chk("Stall", {31'b0, bus.Stall}, {31'b0, st});
    chk("Loop", {31'b0, bus.Loop}, {31'b0, lp});
    chk("PC_in", {16'b0, bus.PC_in}, {16'b0, pcin});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
      m_idpc = 0; m_sq = 0; m_halt = 0; m_ill = 0;
      e_v = 0; e_op = 0; e_rd = 0; e_a = 0; e_b = 0; e_imm = 0; e_pc = 0;
    end else begin
      if (!exs) begin
        if (go) begin
          e_v = exop; e_op = op; e_rd = rd; e_a = av; e_b = bv; e_imm = imm; e_pc = m_idpc;
        end else e_v = 0;
      end
      if (!st) m_idpc = fpc;
      m_sq = lp;
      if (go && op == 5'd31) m_halt = 1;
      if (go && !legal) m_ill = 1;
      if (we) m_busy[wrd] = 0;
      if (go && wrs && rd != 0) m_busy[rd] = 1;
      if (we && wrd != 0) m_rf[wrd] = wd;
    end
    #1;
    chk("ex_valid", {31'b0, bus.ex_valid}, {31'b0, e_v});
    chk("ex_op", {27'b0, bus.ex_op}, {27'b0, e_op});
    chk("ex_rd", {28'b0, bus.ex_rd}, {28'b0, e_rd});
    chk("ex_a", {16'b0, bus.ex_a}, {16'b0, e_a});
    chk("ex_b", {16'b0, bus.ex_b}, {16'b0, e_b});
    chk("ex_imm", {16'b0, bus.ex_imm}, {16'b0, e_imm});
    chk("ex_pc", {16'b0, bus.ex_pc}, {16'b0, e_pc});
    chk("halted", {31'b0, bus.halted}, {31'b0, m_halt});
    chk("illegal", {31'b0, bus.illegal}, {31'b0, m_ill});
  endtask

  initial begin
    logic [4:0] ops [20];
    logic [31:0] ins;
    ops = '{5'h00, 5'h01, 5'h02, 5'h05, 5'h07, 5'h08, 5'h0C, 5'h0F, 5'h10, 5'h10,
            5'h11, 5'h11, 5'h18, 5'h18, 5'h19, 5'h1F, 5'h1A, 5'h13, 5'h03, 5'h09};

    tbl[0]  = mkv(32'h0, 16'h0001, 0, 0, 4'd0, 16'h0,    0, 0, 16'h0,    0, 16'h0000, 16'h0000);
    tbl[1]  = mkv(32'h0, 16'h0002, 0, 0, 4'd0, 16'h0,    0, 0, 16'h0,    0, 16'h0000, 16'h0001);
    tbl[2]  = mkv(rr(5'h01, 4'd2, 4'd1, 4'd0), 16'h0003, 0, 1, 4'd1, 16'h00FF,
                  0, 0, 16'h0, 1, 16'h00FF, 16'h0002);
    tbl[3]  = mkv(ri(5'h10, 4'd3, 4'd1, 16'h0), 16'h0004, 0, 0, 4'd0, 16'h0,
                  0, 0, 16'h0, 1, 16'h00FF, 16'h0003);
    tbl[4]  = mkv(rr(5'h01, 4'd4, 4'd3, 4'd3), 16'h0005, 0, 0, 4'd0, 16'h0,
                  1, 0, 16'h0, 0, 16'h00FF, 16'h0003);
    tbl[5]  = tbl[4];
    tbl[6]  = mkv(rr(5'h01, 4'd4, 4'd3, 4'd3), 16'h0005, 0, 1, 4'd3, 16'h0007,
                  0, 0, 16'h0, 1, 16'h0007, 16'h0004);
    tbl[7]  = mkv(32'h0, 16'h0010, 0, 1, 4'd1, 16'h0005, 0, 0, 16'h0, 0, 16'h0000, 16'h0005);
    tbl[8]  = mkv(ri(5'h18, 4'd0, 4'd1, 16'h0004), 16'h0011, 0, 0, 4'd0, 16'h0,
                  0, 1, 16'h0015, 0, 16'h0005, 16'h0010);
    tbl[9]  = mkv(rr(5'h01, 4'd5, 4'd1, 4'd1), 16'h0015, 0, 0, 4'd0, 16'h0,
                  0, 0, 16'h0, 0, 16'h0005, 16'h0010);
    tbl[10] = mkv(rr(5'h01, 4'd6, 4'd1, 4'd5), 16'h0016, 0, 0, 4'd0, 16'h0,
                  0, 0, 16'h0, 1, 16'h0005, 16'h0015);
    tbl[11] = mkv(rr(5'h01, 4'd7, 4'd1, 4'd0), 16'h0017, 1, 0, 4'd0, 16'h0,
                  1, 0, 16'h0, 1, 16'h0005, 16'h0015);
    tbl[12] = tbl[11];
    tbl[13] = tbl[11];
    tbl[14] = mkv(rr(5'h01, 4'd7, 4'd1, 4'd0), 16'h0017, 0, 0, 4'd0, 16'h0,
                  0, 0, 16'h0, 1, 16'h0005, 16'h0016);
    tbl[15] = mkv(ri(5'h19, 4'd0, 4'd0, 16'h0040), 16'h0018, 0, 0, 4'd0, 16'h0,
                  0, 1, 16'h0040, 0, 16'h0000, 16'h0017);

    reset = 1'b1; bus.id_instr = '0; bus.fe_pc = '0; bus.ex_stall = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    step(1, 32'h0, 16'h0, 0, 0, 4'd0, 16'h0);
    step(1, 32'h0, 16'h0, 0, 0, 4'd0, 16'h0);

    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].ins, tbl[i].fpc, tbl[i].exs, tbl[i].we, tbl[i].wrd, tbl[i].wd);
      chk($sformatf("tbl%0d.Stall", i), {31'b0, s_stall}, {31'b0, tbl[i].st});
      chk($sformatf("tbl%0d.Loop", i), {31'b0, s_loop}, {31'b0, tbl[i].lp});
      chk($sformatf("tbl%0d.PC_in", i), {16'b0, s_pcin}, {16'b0, tbl[i].pcin});
      chk($sformatf("tbl%0d.ex_valid", i), {31'b0, bus.ex_valid}, {31'b0, tbl[i].v});
      chk($sformatf("tbl%0d.ex_a", i), {16'b0, bus.ex_a}, {16'b0, tbl[i].a});
      chk($sformatf("tbl%0d.ex_pc", i), {16'b0, bus.ex_pc}, {16'b0, tbl[i].pc});
    end

    // HALT freezes fetch; an undefined opcode while halted is never decoded.
    step(1, 32'h0, 16'h0, 0, 0, 4'd0, 16'h0);
    step(0, ri(5'h1F, 4'd0, 4'd0, 16'h0), 16'h0001, 0, 0, 4'd0, 16'h0);
    chk("halt.Stall0", {31'b0, s_stall}, 32'd0);
    chk("halt.halted", {31'b0, bus.halted}, 32'd1);
    step(0, 32'h0, 16'h0002, 0, 1, 4'd2, 16'h1234);
    chk("halt.Stall1", {31'b0, s_stall}, 32'd1);
    step(0, {5'h1A, 27'h0}, 16'h0002, 0, 0, 4'd0, 16'h0);
    chk("halt.Stall2", {31'b0, s_stall}, 32'd1);
    chk("halt.noill", {31'b0, bus.illegal}, 32'd0);
    step(1, {5'h1A, 27'h0}, 16'h0002, 0, 0, 4'd0, 16'h0);
    chk("rst.halted", {31'b0, bus.halted}, 32'd0);
    chk("rst.ex_pc", {16'b0, bus.ex_pc}, 32'd0);
    step(0, {5'h1A, 27'h0}, 16'h0003, 0, 0, 4'd0, 16'h0);
    chk("ill.Stall", {31'b0, s_stall}, 32'd0);
    chk("ill.illegal", {31'b0, bus.illegal}, 32'd1);
    chk("ill.ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    step(0, 32'h0, 16'h0004, 0, 0, 4'd0, 16'h0);
    chk("ill.sticky", {31'b0, bus.illegal}, 32'd1);

    // random traffic, narrow register range to provoke hazards
    step(1, 32'h0, 16'h0, 0, 0, 4'd0, 16'h0);
    for (int c = 0; c < 4000; c++) begin
      ins = ri(ops[$urandom_range(19)], 4'($urandom_range(7)), 4'($urandom_range(7)),
               16'($urandom));
      ins[18:15] = 4'($urandom_range(7));
      step(($urandom_range(59) == 0), ins, 16'($urandom), ($urandom_range(4) == 0),
           ($urandom_range(2) == 0), 4'($urandom_range(7)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode / issue stage of the pipelined GPU core, directly downstream of the fetch stage. It consumes `id_instr` and the fetch PC, reads a 16×16-bit scalar register file, and detects RAW hazards with a scoreboard. It resolves branches/jumps by driving `Loop`/`PC_in` back to fetch, and issues registered operands to the execute stage.

## Interface
Parameters:
- `NREG`, 16: scalar register count; r0 reads 0, writes ignored, never busy.
- `DW`, 16: register / datapath width.

Ports:
- `CLOCK_50`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_instr`  in  32  instruction from fetch.
- `fe_pc`  in  16  fetch `PC_out`; leads `id_instr` by one cycle.
- `Stall`  out  1  to fetch; holds fetch when 1.
- `Loop`  out  1  to fetch; redirect fetch to `PC_in`.
- `PC_in`  out  16  redirect target.
- `ex_stall`  in  1  execute cannot accept; hold issue outputs.
- `ex_valid`  out  1  issue slot holds a real instruction.
- `ex_op`  out  5  opcode.
- `ex_rd`  out  4  destination register.
- `ex_a`, `ex_b`  out  16  rs / rt operand values.
- `ex_imm`  out  16  `instr[15:0]`.
- `ex_pc`  out  16  PC of the issued instruction.
- `wb_we`  in  1  writeback enable.
- `wb_rd`  in  4  writeback register.
- `wb_data`  in  16  writeback value.
- `halted`  out  1  sticky; HALT issued.
- `illegal`  out  1  sticky; undefined opcode decoded.

## Operation
- Fields: `op=[31:27]`, `rd=[26:23]`, `rs=[22:19]`, `rt=[18:15]`, `imm=[15:0]`.
- Opcodes and register use:
  - `00`: NOP.
  - `01–07`: ALU reg-reg; reads rs, rt; writes rd.
  - `08–0F`: ALU imm; reads rs; writes rd.
  - `10`: LD; reads rs; writes rd.
  - `11`: ST; reads rs, rt.
  - `18`: BNZ; reads rs.
  - `19`: JMP.
  - `1F`: HALT.
  - Any other opcode: treated as NOP and sets `illegal`.
- Internal `id_pc` register is updated to `fe_pc` whenever fetch advances (`Stall==0`). It is the PC of the current `id_instr`.
- Register file: written on `wb_we && wb_rd!=0`. Same-cycle write/read bypass: a read of `wb_rd` returns `wb_data`.
- Scoreboard:
  - One busy bit per register.
  - Set at issue of any instruction that writes rd≠0.
  - Cleared on `wb_we` for `wb_rd`.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: any source register (rs/rt as used) busy, or `ex_stall` → `Stall=1`, `Loop=0`, nothing issued, decode re-evaluated next cycle.
- Issue (no hazard, not squashed, not halted):
  - Capture fields, operands and `id_pc` into `ex_*`.
  - `ex_valid=1` for ALU/LD/ST.
  - `ex_valid=0` for NOP/BNZ/JMP/illegal.
- Branch, resolved in decode, combinational in the issue cycle:
  - BNZ taken when rs value ≠ 0: `PC_in = id_pc + 1 + imm` (mod 2^16).
  - JMP: `PC_in = imm`.
  - `Loop=1` for exactly that cycle.
  - `PC_in=0` whenever `Loop=0`.
- Squash: the cycle after `Loop=1`, `id_instr` is the stale fall-through word. It is discarded: no issue, no scoreboard set, no `illegal`.
- HALT: sets `halted`; `Stall` then held 1 until reset. Writebacks continue to clear the scoreboard.

## Timing
- Reset (synchronous): all outputs 0, `id_pc=0`, scoreboard clear, all registers 0, squash flag 0, `halted=0`, `illegal=0`. Reset overrides in-flight stalls, squash and halt.
- `Stall`, `Loop`, `PC_in` are combinational from current state and inputs; fetch samples them at the next edge.
- `ex_*` are registered: one-cycle latency from decode to issue.
- While `ex_stall=1`, all `ex_*` hold their values.
- If neither `ex_stall` nor issue applies, `ex_valid` drops to 0 (bubble).
- Taken branch costs 1 bubble (squash cycle).
- A branch whose rs is busy stalls; `Loop` is never asserted while `Stall=1`.
- A writeback that clears a hazard in cycle t allows issue in cycle t (bypass plus clear are both visible).

## Test plan
- Reset then NOP stream → all outputs 0, `ex_valid=0`; `ex_pc` follows `id_pc`.
- Write r1 via `wb_we`=1, `wb_rd`=1, `wb_data`=`16'h00FF` in the same cycle as decoding ADD r2,r1,r0 → `ex_a=00FF` at the next edge (bypass).
- LD r3 issued; next instruction ADD r4,r3,r3 → `Stall=1`, `ex_valid=0` until `wb_we`/`wb_rd`=3; ADD issues in the writeback cycle; scoreboard r4 set.
- BNZ r1 (r1=5, `id_pc=0x0010`, imm=`0x0004`) → `Loop=1`, `PC_in=0x0015` for one cycle; next `id_instr` squashed; the target instruction issues with `ex_pc=0x0015`.
- `ex_stall=1` for 3 cycles while ALU decoded → `ex_*` frozen, `Stall=1`; issue happens the cycle after release.
- HALT, then opcode `5'h1A` sequence and mid-stream reset → `halted=1`, `Stall` stuck at 1; reset clears everything; `5'h1A` after reset sets `illegal=1` and `ex_valid=0`.
